// File: rtl/alu_serial_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU sequencer: opcode encodings as
// seen on the request bus and the sequencer state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Request-bus opcode encodings. OP_SUB never reaches the 1-bit slice:
    // the sequencer rewrites it as an ADD with inverted B and carry-in of 1.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Majority function used for the ripple carry of the 1-bit slice
    function automatic logic carry_maj(input logic a, input logic b, input logic c);
        carry_maj = (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// ---------------------------------------------------------------------------
// alu_serial_seq_if
// Request/response bundle of the bit-serial ALU sequencer.
//   Request  : in_valid, in_ready, in_a, in_b, in_op
//   Response : out_valid, out_ready, out_y, out_cout, out_zero
// master modport = operand fetch / writeback side, slave modport = sequencer.
// ---------------------------------------------------------------------------
interface alu_serial_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_cout;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_cout, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_cout, out_zero
    );
endinterface

// File: rtl/alu_serial_seq_alu1.sv
// ---------------------------------------------------------------------------
// alu1
// Combinational 1-bit ALU slice.
//   a, b  in  1  operand bits
//   cin   in  1  carry in (ADD only)
//   op    in  3  ADD/AND/OR/XOR/NOT A; any other code yields y=0, cout=0
//   y     out 1  result bit
//   cout  out 1  carry out (ADD only, else 0)
// ---------------------------------------------------------------------------
module alu1
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       y,
    output logic       cout
);

    // Per-bit function select; only ADD produces a carry
    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin
                y    = a ^ b ^ cin;
                cout = carry_maj(a, b, cin);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            default: begin
                y    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// ---------------------------------------------------------------------------
// alu_serial_seq
// Bit-serial ALU sequencer. Accepts an operand pair and opcode, runs one
// alu1 slice LSB-first for WIDTH clocks with a recirculated carry, then
// presents result plus carry/zero flags until the consumer takes them.
//   clk    in  1  clock, rising edge
//   rst_n  in  1  synchronous active-low reset
//   bus    slave modport of alu_serial_seq_if (request + response)
// ---------------------------------------------------------------------------
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_serial_seq_if.slave  bus
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_e           state_r;
    state_e           next_state_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] result_r;
    logic [2:0]       op_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] out_y_r;
    logic             out_cout_r;
    logic             out_zero_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             is_sub_s;
    logic             slice_b_s;
    logic [2:0]       slice_op_s;
    logic             slice_y_s;
    logic             slice_cout_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] result_next_s;

    // Subtraction is a + ~b + 1, so the slice only ever sees ADD
    always_comb begin
        is_sub_s   = (op_r == OP_SUB);
        last_bit_s = (cnt_r == LAST_CNT);
        if (is_sub_s) begin
            slice_b_s  = ~b_sr_r[0];
            slice_op_s = OP_ADD;
        end else begin
            slice_b_s  = b_sr_r[0];
            slice_op_s = op_r;
        end
    end

    alu1 u_alu1 (
        .a    (a_sr_r[0]),
        .b    (slice_b_s),
        .cin  (carry_r),
        .op   (slice_op_s),
        .y    (slice_y_s),
        .cout (slice_cout_s)
    );

    // Result fills from the MSB end so bit 0 lands in place after WIDTH steps
    if (WIDTH == 1) begin : g_res_w1
        assign result_next_s = slice_y_s;
    end else begin : g_res_wn
        assign result_next_s = {slice_y_s, result_r[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (next_state_s == ST_DONE);
        end
    end

    // Operand capture, serial datapath and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr_r     <= '0;
            b_sr_r     <= '0;
            result_r   <= '0;
            op_r       <= 3'b000;
            carry_r    <= 1'b0;
            cnt_r      <= '0;
            out_y_r    <= '0;
            out_cout_r <= 1'b0;
            out_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_r   <= bus.in_a;
                        b_sr_r   <= bus.in_b;
                        op_r     <= bus.in_op;
                        carry_r  <= (bus.in_op == OP_SUB);
                        cnt_r    <= '0;
                        result_r <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    result_r <= result_next_s;
                    carry_r  <= slice_cout_s;
                    cnt_r    <= cnt_r + 1'b1;
                    // Output registers load on the final bit; held through DONE
                    if (last_bit_s) begin
                        out_y_r    <= result_next_s;
                        out_cout_r <= slice_cout_s;
                        out_zero_r <= ~|result_next_s;
                    end
                end
                ST_DONE: begin
                    out_y_r <= out_y_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.out_zero  = out_zero_r;

endmodule

// File: tb/tb_alu_serial_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_seq
// Directed bench for alu_serial_seq: an 8-bit instance for arithmetic, logic,
// backpressure, busy-input and reset-abort cases, plus a 1-bit instance.
// ---------------------------------------------------------------------------
module tb_alu_serial_seq;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_serial_seq_if #(.WIDTH(8)) bus8 ();
    alu_serial_seq_if #(.WIDTH(1)) bus1 ();

    alu_serial_seq #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    alu_serial_seq #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation: accept, check latency, flags, optional hold in DONE
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] ey, input logic ec,
                        input logic ez, input int hold, input bit busy);
        int waited = 0;
        while (bus8.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, ":in_ready_idle"}, 16'(bus8.in_ready), 16'h0001);
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_op    = op;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (busy) begin
                bus8.in_valid = 1'b1;
                bus8.in_a     = 8'h00;
                bus8.in_b     = 8'hFF;
                bus8.in_op    = OP_XOR;
            end
            tick();
            if (i < 8) begin
                check({tag, ":out_valid_early"}, 16'(bus8.out_valid), 16'h0000);
                check({tag, ":in_ready_run"}, 16'(bus8.in_ready), 16'h0000);
            end
        end
        bus8.in_valid = 1'b0;
        check({tag, ":out_valid"}, 16'(bus8.out_valid), 16'h0001);
        check({tag, ":out_y"}, 16'(bus8.out_y), 16'(ey));
        check({tag, ":out_cout"}, 16'(bus8.out_cout), 16'(ec));
        check({tag, ":out_zero"}, 16'(bus8.out_zero), 16'(ez));
        check({tag, ":in_ready_done"}, 16'(bus8.in_ready), 16'h0000);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, ":hold_valid"}, 16'(bus8.out_valid), 16'h0001);
            check({tag, ":hold_y"}, 16'(bus8.out_y), 16'(ey));
            check({tag, ":hold_in_ready"}, 16'(bus8.in_ready), 16'h0000);
        end
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check({tag, ":back_idle_ready"}, 16'(bus8.in_ready), 16'h0001);
        check({tag, ":back_idle_valid"}, 16'(bus8.out_valid), 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus8.in_valid  = 1'b0;
        bus8.in_a      = 8'h00;
        bus8.in_b      = 8'h00;
        bus8.in_op     = 3'b000;
        bus8.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = 1'b0;
        bus1.in_b      = 1'b0;
        bus1.in_op     = 3'b000;
        bus1.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst:in_ready", 16'(bus8.in_ready), 16'h0001);
        check("rst:out_valid", 16'(bus8.out_valid), 16'h0000);
        check("rst:out_y", 16'(bus8.out_y), 16'h0000);
        check("rst:out_cout", 16'(bus8.out_cout), 16'h0000);
        check("rst:out_zero", 16'(bus8.out_zero), 16'h0000);
        rst_n = 1'b1;
        tick();

        // Arithmetic
        run8("add_ff_01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        run8("add_12_34", 8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b0, 0, 1'b0);
        run8("sub_05_07", 8'h05, 8'h07, OP_SUB, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
        run8("sub_07_07", 8'h07, 8'h07, OP_SUB, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        run8("sub_09_03", 8'h09, 8'h03, OP_SUB, 8'h06, 1'b1, 1'b0, 0, 1'b0);

        // Logic
        run8("and", 8'hC3, 8'h5A, OP_AND,  8'h42, 1'b0, 1'b0, 0, 1'b0);
        run8("or",  8'hC3, 8'h5A, OP_OR,   8'hDB, 1'b0, 1'b0, 0, 1'b0);
        run8("xor", 8'hC3, 8'h5A, OP_XOR,  8'h99, 1'b0, 1'b0, 0, 1'b0);
        run8("nota", 8'hC3, 8'h5A, OP_NOTA, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
        run8("op110", 8'hC3, 8'h5A, 3'b110, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        run8("op111", 8'hFF, 8'hFF, 3'b111, 8'h00, 1'b0, 1'b1, 0, 1'b0);

        // Backpressure: 5 cycles without out_ready in DONE
        run8("bp", 8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b1, 5, 1'b0);

        // Busy input: new requests during RUN/DONE are ignored
        run8("busy", 8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b0, 0, 1'b1);

        // Reset during the third RUN cycle aborts the operation
        bus8.in_a     = 8'hF0;
        bus8.in_b     = 8'h0F;
        bus8.in_op    = OP_OR;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_run:in_ready", 16'(bus8.in_ready), 16'h0001);
        check("rst_run:out_valid", 16'(bus8.out_valid), 16'h0000);
        check("rst_run:out_y", 16'(bus8.out_y), 16'h0000);
        check("rst_run:out_cout", 16'(bus8.out_cout), 16'h0000);
        check("rst_run:out_zero", 16'(bus8.out_zero), 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_run:no_valid", 16'(bus8.out_valid), 16'h0000);
        end

        // WIDTH=1 instance: ADD 1+1 -> y=0, cout=1, one RUN cycle
        check("w1_add:in_ready", 16'(bus1.in_ready), 16'h0001);
        bus1.in_a     = 1'b1;
        bus1.in_b     = 1'b1;
        bus1.in_op    = OP_ADD;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("w1_add:run_valid", 16'(bus1.out_valid), 16'h0000);
        tick();
        check("w1_add:out_valid", 16'(bus1.out_valid), 16'h0001);
        check("w1_add:out_y", 16'(bus1.out_y), 16'h0000);
        check("w1_add:out_cout", 16'(bus1.out_cout), 16'h0001);
        check("w1_add:out_zero", 16'(bus1.out_zero), 16'h0001);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("w1_add:idle", 16'(bus1.in_ready), 16'h0001);

        // WIDTH=1 instance: SUB 0-1 -> y=1, borrow (cout=0)
        bus1.in_a     = 1'b0;
        bus1.in_b     = 1'b1;
        bus1.in_op    = OP_SUB;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        tick();
        check("w1_sub:out_valid", 16'(bus1.out_valid), 16'h0001);
        check("w1_sub:out_y", 16'(bus1.out_y), 16'h0001);
        check("w1_sub:out_cout", 16'(bus1.out_cout), 16'h0000);
        check("w1_sub:out_zero", 16'(bus1.out_zero), 16'h0000);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("w1_sub:idle", 16'(bus1.in_ready), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
